msg_frame_rx: RTL and testbench
===============================

// Module: msg_frame_rx
// PURPOSE
//  Parametrised UART message-frame receiver/decoder; sits between uart_rx byte output and the bot controller.
//  Buffers '#'-terminated ASCII frames and decodes IFM fault and PBM pick-block messages.
//  Emits per-unit fault and pick-block events plus a frame-error event.
//  Also provides the post-start arming delay.
// PARAMETERS
//  MAX_LEN      12             frame buffer depth in bytes, including '#'; >=11
//  NUM_UNITS    3              fault units; unit i code = UNIT_CODES byte i (LSB byte = unit 0)
//  UNIT_CODES   24'h52_43_45   ASCII unit letters, packed {R,C,E}
//  NUM_BLOCKS   4              pick-block locations; digit '1'..('0'+NUM_BLOCKS)
//  START_DELAY  1_500_000_000  clk_50M cycles from start request to armed (30 s)
//  STICKY       0              0: event outputs are 1-cycle pulses; 1: flags held until flag_clr
// PORTS
//  clk_50M         in   1                        system clock, 50 MHz
//  rst_n           in   1                        synchronous active-low reset
//  rx_msg          in   8                        received byte, valid while rx_complete high
//  rx_complete     in   1                        byte-ready level; a byte is taken on its rising edge only
//  start_n         in   1                        active-low start request (key0)
//  flag_clr        in   1                        clears sticky flags (STICKY=1 only)
//  fault_flag      out  NUM_UNITS                fault event per unit
//  pick_block_flag out  1                        PBM frame decoded
//  block_location  out  $clog2(NUM_BLOCKS)       block index from last valid PBM
//  frame_err       out  1                        1-cycle pulse: overflow or unrecognised frame
//  armed           out  1                        high once START_DELAY elapsed (switch_key)
// BEHAVIOUR
//  Reset: all outputs 0, buffer length 0, FSM=COLLECT, delay counter 0, rx edge register 0.
//  Byte accept: rx_complete 0->1 in registered edge detector; one byte per rising edge.
//  FSM COLLECT: store byte at buf[len], len++.
//   '#' -> DECODE.
//   len reaches MAX_LEN without '#' -> frame_err pulse, go DISCARD.
//  DISCARD: drop bytes until '#', then len=0, return to COLLECT; no decode.
//  DECODE (1 cycle): decode buf[0..len-1], set len=0, return to COLLECT. Outputs registered.
//   Net latency: '#' rising edge at cycle N -> event outputs valid at N+2.
//  Byte edge arriving in DECODE: held in 1-entry pending register and written as byte 0 next cycle; never lost.
//  IFM: buf[0..3]="IFM-", buf[4]==UNIT_CODES[i] -> fault_flag[i]; other letter -> frame_err.
//  PBM: buf[0..10]="PBM-SU-Bd-#", d in '1'..'0'+NUM_BLOCKS ->
//   pick_block_flag and block_location=d-'1'; d out of range -> frame_err, block_location unchanged.
//  Any other frame, including a lone '#' (len 1) -> frame_err.
//  Bytes past the frame length are never compared; no buffer clearing needed.
//  STICKY=0: event outputs high exactly one cycle.
//  STICKY=1: events OR into flags; flag_clr clears them.
//   flag_clr and a new event in the same cycle -> new event wins (flag set).
//  Arming: start_n low (registered) starts counting; count saturates at START_DELAY and armed=1.
//   Releasing start_n before expiry freezes the count; armed stays 1 until reset.
//  Reset mid-frame: partial frame discarded, no event emitted.
// STRUCTURE
//  Shared package msg_pkg: ASCII constants (CH_HASH 8'h23, CH_DASH, I/F/M/P/B/S/U), frame-type enum
//   {FT_NONE, FT_IFM, FT_PBM, FT_ERR}.
//  Sub-module msg_frame_decode: combinational buffer -> {frame type, unit one-hot, block idx, err}.
//  Top holds edge detect, buffer, FSM, output regs, arming counter.
// TESTING
//  Send "IFM-E-#" (STICKY=0) -> fault_flag=3'b001 for 1 cycle at '#'edge+2; no frame_err.
//  Send "PBM-SU-B3-#" -> pick_block_flag pulse, block_location=2; then "PBM-SU-B9-#" -> frame_err, location stays 2.
//  Send 13 bytes "AAAAAAAAAAAAA" then "IFM-C-#" -> one frame_err at byte 12; next frame gives fault_flag=3'b010.
//  rx_complete held high 40 cycles per byte -> each byte taken once; a byte edge in the DECODE cycle lands as byte 0.
//  START_DELAY=100: start_n low 1 cycle -> armed rises after exactly 100 counted cycles; rst_n low drops armed.
//  STICKY=1: "IFM-R-#" then flag_clr coincident with "IFM-E-#" event -> fault_flag=3'b101, then 0 after clear.

Source files
------------

// File: rtl/msg_pkg.sv
// Shared definitions for the message-frame receiver.
//   ASCII codes for the frame keywords, the decoded frame-type enum,
//   receiver FSM state encodings and a width helper.
package msg_pkg;

  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_DASH = 8'h2D;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_1    = 8'h31;
  localparam logic [7:0] CH_B    = 8'h42;
  localparam logic [7:0] CH_F    = 8'h46;
  localparam logic [7:0] CH_I    = 8'h49;
  localparam logic [7:0] CH_M    = 8'h4D;
  localparam logic [7:0] CH_P    = 8'h50;
  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_U    = 8'h55;

  // Longest recognised frame is "PBM-SU-Bd-#"; nothing beyond it is ever compared.
  localparam int DEC_BYTES = 11;

  typedef enum logic [1:0] {
    FT_NONE = 2'd0,
    FT_IFM  = 2'd1,
    FT_PBM  = 2'd2,
    FT_ERR  = 2'd3
  } frame_type_e;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_DISCARD = 2'd1;
  localparam logic [1:0] ST_DECODE  = 2'd2;

  // Bits needed to hold any value 0..max_val (at least 1).
  function automatic int cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/msg_frame_decode.sv
// Combinational frame classifier.
//   frame_i      first DEC_BYTES bytes of the frame buffer, byte 0 in the LSBs
//   len_i        frame length in bytes, including the terminating '#'
//   ftype_o      FT_IFM / FT_PBM / FT_ERR
//   unit_oh_o    one-hot fault unit (IFM only, else 0)
//   block_idx_o  block index d-'1' (PBM only, else 0)
//   err_o        frame not recognised
module msg_frame_decode
  import msg_pkg::*;
#(
  parameter int                     MAX_LEN    = 12,
  parameter int                     NUM_UNITS  = 3,
  parameter logic [8*NUM_UNITS-1:0] UNIT_CODES = 24'h52_43_45,
  parameter int                     NUM_BLOCKS = 4,
  localparam int                    LW         = cnt_width(MAX_LEN),
  localparam int                    BW         = cnt_width(NUM_BLOCKS - 1)
) (
  input  logic [8*DEC_BYTES-1:0] frame_i,
  input  logic [LW-1:0]          len_i,
  output frame_type_e            ftype_o,
  output logic [NUM_UNITS-1:0]   unit_oh_o,
  output logic [BW-1:0]          block_idx_o,
  output logic                   err_o
);

  logic [DEC_BYTES-1:0][7:0] b;
  logic                      is_ifm;
  logic                      is_pbm;
  logic                      digit_ok;
  logic [7:0]                digit;
  logic [NUM_UNITS-1:0]      unit_hit;

  assign b = frame_i;

  // len >= 5 keeps the unit letter inside the frame; stale bytes never match.
  assign is_ifm = (len_i >= LW'(5)) && b[0] == CH_I && b[1] == CH_F &&
                  b[2] == CH_M && b[3] == CH_DASH;

  assign is_pbm = (len_i == LW'(11)) && b[0] == CH_P && b[1] == CH_B &&
                  b[2] == CH_M && b[3] == CH_DASH && b[4] == CH_S &&
                  b[5] == CH_U && b[6] == CH_DASH && b[7] == CH_B &&
                  b[9] == CH_DASH && b[10] == CH_HASH;

  assign digit    = b[8];
  assign digit_ok = (digit >= CH_1) && (digit <= CH_0 + 8'(NUM_BLOCKS));

  always_comb begin
    unit_hit = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      unit_hit[i] = (b[4] == UNIT_CODES[8*i +: 8]);
    end
  end

  always_comb begin
    ftype_o     = FT_ERR;
    unit_oh_o   = '0;
    block_idx_o = '0;
    if (is_ifm && |unit_hit) begin
      ftype_o   = FT_IFM;
      unit_oh_o = unit_hit;
    end else if (is_pbm && digit_ok) begin
      ftype_o     = FT_PBM;
      block_idx_o = BW'(digit - CH_1);
    end
  end

  assign err_o = (ftype_o == FT_ERR);

endmodule

// File: rtl/msg_frame_rx.sv
// UART message-frame receiver: collects '#'-terminated ASCII frames from the
// byte receiver, decodes IFM fault / PBM pick-block messages and provides the
// post-start arming delay.
//   clk_50M, rst_n          clock, synchronous active-low reset
//   rx_msg, rx_complete     byte and byte-ready level (taken on rising edge)
//   start_n                 active-low start request
//   flag_clr                clears held flags when STICKY=1
//   fault_flag              per-unit fault event
//   pick_block_flag         PBM frame decoded
//   block_location          block index from the last valid PBM
//   frame_err               1-cycle pulse on overflow or unrecognised frame
//   armed                   start delay elapsed
//
// state      | meaning
// COLLECT    | storing bytes, waiting for '#'
// DISCARD    | overflowed, dropping bytes up to the next '#'
// DECODE     | one cycle: classify buffer, register events, restart
module msg_frame_rx
  import msg_pkg::*;
#(
  parameter int                     MAX_LEN     = 12,
  parameter int                     NUM_UNITS   = 3,
  parameter logic [8*NUM_UNITS-1:0] UNIT_CODES  = 24'h52_43_45,
  parameter int                     NUM_BLOCKS  = 4,
  parameter int unsigned            START_DELAY = 1_500_000_000,
  parameter int                     STICKY      = 0,
  localparam int                    BW          = cnt_width(NUM_BLOCKS - 1)
) (
  input  logic                 clk_50M,
  input  logic                 rst_n,
  input  logic [7:0]           rx_msg,
  input  logic                 rx_complete,
  input  logic                 start_n,
  input  logic                 flag_clr,
  output logic [NUM_UNITS-1:0] fault_flag,
  output logic                 pick_block_flag,
  output logic [BW-1:0]        block_location,
  output logic                 frame_err,
  output logic                 armed
);

  localparam int LW = cnt_width(MAX_LEN);
  localparam int CW = cnt_width(START_DELAY);

  logic                      rx_q;
  logic [1:0]                state_q, state_d;
  logic [LW-1:0]             len_q, len_d;
  logic [DEC_BYTES-1:0][7:0] buf_q, buf_d;
  logic                      pend_vld_q, pend_vld_d;
  logic [7:0]                pend_q, pend_d;
  logic [NUM_UNITS-1:0]      fault_q, fault_d;
  logic                      pick_q, pick_d;
  logic [BW-1:0]             loc_q, loc_d;
  logic                      ferr_q, ferr_d;
  logic                      start_q, start_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      armed_q, armed_d;

  logic                      rise;
  logic                      in_vld;
  logic [7:0]                in_byte;
  logic [NUM_UNITS-1:0]      ev_fault;
  logic                      ev_pick;

  frame_type_e               dec_type;
  logic [NUM_UNITS-1:0]      dec_unit;
  logic [BW-1:0]             dec_idx;
  logic                      dec_err;

  assign rise = rx_complete & ~rx_q;

  msg_frame_decode #(
    .MAX_LEN    (MAX_LEN),
    .NUM_UNITS  (NUM_UNITS),
    .UNIT_CODES (UNIT_CODES),
    .NUM_BLOCKS (NUM_BLOCKS)
  ) u_decode (
    .frame_i     (buf_q),
    .len_i       (len_q),
    .ftype_o     (dec_type),
    .unit_oh_o   (dec_unit),
    .block_idx_o (dec_idx),
    .err_o       (dec_err)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    buf_d      = buf_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    loc_d      = loc_q;
    ferr_d     = 1'b0;
    ev_fault   = '0;
    ev_pick    = 1'b0;
    in_vld     = 1'b0;
    in_byte    = rx_msg;

    // A byte parked during DECODE is consumed first; a fresh edge in the same
    // cycle takes its place in the pending register.
    if (state_q != ST_DECODE) begin
      in_vld = pend_vld_q | rise;
      if (pend_vld_q) begin
        in_byte    = pend_q;
        pend_vld_d = rise;
        if (rise) pend_d = rx_msg;
      end
    end

    case (state_q)
      ST_COLLECT: begin
        if (in_vld) begin
          // Only the first DEC_BYTES positions are stored; later bytes are
          // never compared by the decoder.
          for (int i = 0; i < DEC_BYTES; i++) begin
            if (len_q == LW'(i)) buf_d[i] = in_byte;
          end
          len_d = len_q + LW'(1);
          if (in_byte == CH_HASH) begin
            state_d = ST_DECODE;
          end else if (len_q == LW'(MAX_LEN - 1)) begin
            ferr_d  = 1'b1;
            len_d   = '0;
            state_d = ST_DISCARD;
          end
        end
      end
      ST_DISCARD: begin
        if (in_vld && in_byte == CH_HASH) state_d = ST_COLLECT;
      end
      ST_DECODE: begin
        state_d = ST_COLLECT;
        len_d   = '0;
        if (rise) begin
          pend_vld_d = 1'b1;
          pend_d     = rx_msg;
        end
        if (dec_type == FT_IFM) ev_fault = dec_unit;
        if (dec_type == FT_PBM) begin
          ev_pick = 1'b1;
          loc_d   = dec_idx;
        end
        ferr_d = dec_err;
      end
      default: begin
        state_d = ST_COLLECT;
        len_d   = '0;
      end
    endcase

    // Held flags: a new event beats a simultaneous clear.
    if (STICKY == 0) begin
      fault_d = ev_fault;
      pick_d  = ev_pick;
    end else begin
      fault_d = fault_q;
      if (|ev_fault)     fault_d = fault_q | ev_fault;
      else if (flag_clr) fault_d = '0;
      pick_d = pick_q;
      if (ev_pick)       pick_d = 1'b1;
      else if (flag_clr) pick_d = 1'b0;
    end

    // Count only while start is requested; the count freezes on release.
    start_d = ~start_n;
    cnt_d   = cnt_q;
    if (start_q && cnt_q != CW'(START_DELAY)) cnt_d = cnt_q + CW'(1);
    armed_d = armed_q | (cnt_d == CW'(START_DELAY));
  end

  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      rx_q       <= 1'b0;
      state_q    <= ST_COLLECT;
      len_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      fault_q    <= '0;
      pick_q     <= 1'b0;
      loc_q      <= '0;
      ferr_q     <= 1'b0;
      start_q    <= 1'b0;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
    end else begin
      rx_q       <= rx_complete;
      state_q    <= state_d;
      len_q      <= len_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      fault_q    <= fault_d;
      pick_q     <= pick_d;
      loc_q      <= loc_d;
      ferr_q     <= ferr_d;
      start_q    <= start_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
    end
  end

  // Buffer contents beyond len are never looked at, so no reset is needed.
  always_ff @(posedge clk_50M) begin
    buf_q <= buf_d;
  end

  assign fault_flag      = fault_q;
  assign pick_block_flag = pick_q;
  assign block_location  = loc_q;
  assign frame_err       = ferr_q;
  assign armed           = armed_q;

endmodule

// File: tb/tb_msg_frame_rx.sv
// Testbench for msg_frame_rx: directed and random frames checked against a
// byte-stream reference model through a scoreboard; sticky-flag and arming
// behaviour checked directly on a second instance.
module tb_msg_frame_rx;

  localparam int MAX_LEN = 12;
  localparam int NB      = 4;
  localparam int SD      = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_msg = 8'h00;
  logic       rx_complete = 1'b0;
  logic       start_n = 1'b1;
  logic       flag_clr = 1'b0;

  logic [2:0] ff0, ff1;
  logic       pb0, pb1, fe0, fe1, ar0, ar1;
  logic [1:0] bl0, bl1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  msg_frame_rx #(.START_DELAY(SD), .STICKY(0)) u_dut (
    .clk_50M(clk), .rst_n(rst_n), .rx_msg(rx_msg), .rx_complete(rx_complete),
    .start_n(start_n), .flag_clr(flag_clr), .fault_flag(ff0),
    .pick_block_flag(pb0), .block_location(bl0), .frame_err(fe0), .armed(ar0));

  msg_frame_rx #(.START_DELAY(SD), .STICKY(1)) u_dut_s (
    .clk_50M(clk), .rst_n(rst_n), .rx_msg(rx_msg), .rx_complete(rx_complete),
    .start_n(start_n), .flag_clr(flag_clr), .fault_flag(ff1),
    .pick_block_flag(pb1), .block_location(bl1), .frame_err(fe1), .armed(ar1));

  typedef struct {
    int         cyc;
    logic [2:0] fault;
    logic       pick;
    logic [1:0] loc;
    logic       err;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] frm[$];
  bit         disc = 1'b0;
  logic [1:0] mloc = 2'd0;
  string      units = "ECR";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit pat(input int off, input string p);
    for (int i = 0; i < p.len(); i++) begin
      if (off + i >= frm.size()) return 1'b0;
      if (frm[off+i] != p[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int unit_of(input logic [7:0] ch);
    for (int i = 0; i < units.len(); i++) if (units[i] == ch) return i;
    return -1;
  endfunction

  // Reference model over the byte stream; c is the cycle the byte is driven.
  task automatic model_byte(input logic [7:0] b, input int c);
    exp_t e;
    int   u;
    if (disc) begin
      if (b == "#") disc = 1'b0;
      return;
    end
    frm.push_back(b);
    if (b == "#") begin
      e.cyc = c + 2; e.fault = 3'b000; e.pick = 1'b0; e.err = 1'b0;
      u = (frm.size() >= 5) ? unit_of(frm[4]) : -1;
      if (frm.size() >= 5 && pat(0, "IFM-") && u >= 0) begin
        e.fault = 3'(1 << u);
      end else if (frm.size() == 11 && pat(0, "PBM-SU-B") && pat(9, "-#") &&
                   frm[8] >= 8'h31 && frm[8] <= 8'(8'h30 + NB)) begin
        mloc   = 2'(frm[8] - 8'h31);
        e.pick = 1'b1;
      end else begin
        e.err = 1'b1;
      end
      e.loc = mloc;
      sbq.push_back(e);
      frm.delete();
    end else if (frm.size() == MAX_LEN) begin
      e.cyc = c + 1; e.fault = 3'b000; e.pick = 1'b0; e.loc = mloc; e.err = 1'b1;
      sbq.push_back(e);
      disc = 1'b1;
      frm.delete();
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        checks++;
        if ({ff0, pb0, bl0, fe0} !== {e.fault, e.pick, e.loc, e.err} || e.cyc != cyc) begin
          errors++;
          $display("FAIL event at cyc %0d: got fault=%b pick=%b loc=%0d err=%b, expected cyc %0d fault=%b pick=%b loc=%0d err=%b",
                   cyc, ff0, pb0, bl0, fe0, e.cyc, e.fault, e.pick, e.loc, e.err);
        end
      end else if (ff0 != 3'b000 || pb0 || fe0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event at cyc %0d: fault=%b pick=%b err=%b", cyc, ff0, pb0, fe0);
      end
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    model_byte(b, cyc);
    rx_msg      = b;
    rx_complete = 1'b1;
    cyc_wait(hold);
    rx_complete = 1'b0;
    cyc_wait(gap);
  endtask

  function automatic int rnd_hold();
    return ($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(1, 3));
  endfunction

  task automatic send_str(input string s, input bit fast);
    for (int i = 0; i < s.len(); i++) begin
      if (fast) send_byte(s[i], 1, 1);
      else      send_byte(s[i], rnd_hold(), int'($urandom_range(1, 3)));
    end
  endtask

  task automatic send_slow(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 40, 2);
  endtask

  task automatic rand_frame();
    string      s, pool;
    logic [7:0] ch;
    int         k, n;
    k = int'($urandom_range(0, 5));
    case (k)
      0, 1: begin
        pool = "ECRXe";
        ch = pool[int'($urandom_range(0, 4))];
        s = $sformatf("IFM-%c-#", ch);
      end
      2: begin
        ch = 8'($urandom_range(48, 57));
        s = $sformatf("PBM-SU-B%c-#", ch);
      end
      3: begin
        s = "";
        n = int'($urandom_range(0, 14));
        for (int j = 0; j < n; j++) begin
          ch = 8'($urandom_range(65, 90));
          s = {s, $sformatf("%c", ch)};
        end
        s = {s, "#"};
      end
      4: begin
        ch = 8'($urandom_range(49, 52));
        s = $sformatf("PBM-SU-B%c-#", ch);
        s.putc(int'($urandom_range(0, 9)), 8'($urandom_range(65, 90)));
      end
      default: begin
        n = int'($urandom_range(0, 2));
        s = (n == 0) ? "IFM-#" : (n == 1) ? "#" : "PBM-SU-B2#";
      end
    endcase
    send_str(s, $urandom_range(0, 3) == 0);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    cyc_wait(1);
    chk("scoreboard_drained", sbq.size(), 0);
  endtask

  task automatic model_reset();
    frm.delete();
    disc = 1'b0;
    mloc = 2'd0;
  endtask

  initial begin
    cyc_wait(3);
    chk("reset_outputs_sticky0", {ff0, pb0, bl0, fe0, ar0}, 0);
    chk("reset_outputs_sticky1", {ff1, pb1, bl1, fe1, ar1}, 0);
    rst_n = 1'b1;
    cyc_wait(2);

    send_str("IFM-E-#", 0);
    send_str("PBM-SU-B3-#", 0);
    send_str("PBM-SU-B9-#", 0);
    send_str("AAAAAAAAAAAAA", 1);
    send_str("IFM-C-#", 0);
    send_str("IFM-C-#", 0);
    send_str("#", 0);
    send_str("IFM-R-#IFM-C-#PBM-SU-B1-#", 1);
    send_slow("IFM-E-#");
    send_str("IFM-", 1);
    send_str("R-#", 1);
    drain();

    for (int f = 0; f < 80; f++) rand_frame();
    drain();

    // Held flags on the STICKY=1 instance.
    flag_clr = 1'b1;
    cyc_wait(1);
    flag_clr = 1'b0;
    chk("sticky_cleared", {ff1, pb1}, 0);
    send_str("IFM-R-#", 1);
    cyc_wait(3);
    chk("sticky_fault_held", ff1, 3'b100);
    send_str("IFM-E-", 1);
    model_byte(8'h23, cyc);
    rx_msg = 8'h23;
    rx_complete = 1'b1;
    cyc_wait(1);
    rx_complete = 1'b0;
    flag_clr = 1'b1;
    cyc_wait(1);
    flag_clr = 1'b0;
    chk("sticky_event_beats_clear", ff1, 3'b101);
    cyc_wait(1);
    flag_clr = 1'b1;
    cyc_wait(1);
    flag_clr = 1'b0;
    chk("sticky_fault_cleared", ff1, 3'b000);
    send_str("PBM-SU-B1-#", 1);
    cyc_wait(4);
    chk("sticky_pick_held", {pb1, bl1}, {1'b1, 2'd0});
    flag_clr = 1'b1;
    cyc_wait(1);
    flag_clr = 1'b0;
    chk("sticky_pick_cleared", {pb1, bl1}, {1'b0, 2'd0});
    drain();

    // Arming: armed follows the 100th sampled start_n low by one cycle.
    start_n = 1'b0;
    cyc_wait(1);
    start_n = 1'b1;
    cyc_wait(20);
    chk("armed_frozen_after_1", {ar0, ar1}, 2'b00);
    start_n = 1'b0;
    cyc_wait(98);
    start_n = 1'b1;
    cyc_wait(10);
    chk("armed_frozen_after_99", {ar0, ar1}, 2'b00);
    start_n = 1'b0;
    cyc_wait(1);
    start_n = 1'b1;
    chk("armed_not_yet", {ar0, ar1}, 2'b00);
    cyc_wait(1);
    chk("armed_rises", {ar0, ar1}, 2'b11);
    cyc_wait(10);
    chk("armed_holds", {ar0, ar1}, 2'b11);

    // Reset in the middle of a frame discards it and drops armed.
    send_str("IFM-", 0);
    rst_n = 1'b0;
    model_reset();
    cyc_wait(1);
    chk("midreset_outputs", {ff0, pb0, bl0, fe0, ar0, ar1}, 0);
    cyc_wait(2);
    rst_n = 1'b1;
    cyc_wait(2);
    send_str("E-#", 0);
    send_str("PBM-SU-B4-#", 0);
    send_str("PBM-SU-B0-#", 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
